// File: rtl/memory_sync.sv
// Single-port word memory that zero-fills itself after reset; optional parity under MEMORY_SYNC_PARITY_EN.
// Latency: read data and valid are registered, one cycle after the accepted read.
// Backpressure: none; requests are ignored while busy is high during the init sweep.
module memory_sync #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic              read,
  output logic [WIDTH-1:0]  out,
  output logic              valid,
  output logic              busy
`ifdef MEMORY_SYNC_PARITY_EN
  ,
  input  logic              inject_err,
  output logic              parity_err
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
`ifdef MEMORY_SYNC_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  typedef enum logic {INIT, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [MW-1:0]     mem [DEPTH];

  logic              in_range;
  logic              acc_wr;
  logic              mem_we;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [MW-1:0]     wr_word;
  logic [MW-1:0]     mem_wdat;
  logic [MW-1:0]     rd_word;

  assign in_range = 32'(address) < DEPTH;
  assign idx      = address[IDX_W-1:0];
  assign acc_wr   = !rst && (state == READY) && write && in_range;

`ifdef MEMORY_SYNC_PARITY_EN
  // Even parity: stored bit makes the total count of ones even; inject flips it.
  assign wr_word = {(^in) ^ inject_err, in};
`else
  assign wr_word = in;
`endif

  assign mem_we   = !rst && ((state == INIT) || acc_wr);
  assign mem_idx  = (state == INIT) ? cnt[IDX_W-1:0] : idx;
  assign mem_wdat = (state == INIT) ? '0 : wr_word;

  // Read and write share one address, so a same-cycle write is always a hit: forward it.
  assign rd_word = acc_wr ? wr_word : (in_range ? mem[idx] : '0);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      busy  <= 1'b1;
      out   <= '0;
      valid <= 1'b0;
`ifdef MEMORY_SYNC_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef MEMORY_SYNC_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        INIT: begin
          cnt <= cnt + ADDR_W'(1);
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (read) begin
            out   <= rd_word[WIDTH-1:0];
            valid <= 1'b1;
`ifdef MEMORY_SYNC_PARITY_EN
            parity_err <= ^rd_word;
`endif
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_sync.sv
// Directed bench for memory_sync: a 256-word and a 200-word instance share clock and reset.
module tb_memory_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in, address, out;
  logic       write, read, valid, busy;
  logic [7:0] s_in, s_address, s_out;
  logic       s_write, s_read, s_valid, s_busy;
`ifdef MEMORY_SYNC_PARITY_EN
  logic       inject_err, parity_err, s_parity_err;
`endif

  memory_sync #(.WIDTH(8), .DEPTH(256), .ADDR_W(8)) u_dut (
    .clk(clk), .rst(rst), .in(in), .address(address), .write(write), .read(read),
    .out(out), .valid(valid), .busy(busy)
`ifdef MEMORY_SYNC_PARITY_EN
    , .inject_err(inject_err), .parity_err(parity_err)
`endif
  );

  memory_sync #(.WIDTH(8), .DEPTH(200), .ADDR_W(8)) u_small (
    .clk(clk), .rst(rst), .in(s_in), .address(s_address), .write(s_write), .read(s_read),
    .out(s_out), .valid(s_valid), .busy(s_busy)
`ifdef MEMORY_SYNC_PARITY_EN
    , .inject_err(1'b0), .parity_err(s_parity_err)
`endif
  );

  typedef struct {
    bit         sm;
    bit         wr;
    bit         rd;
    bit         inj;
    logic [7:0] addr;
    logic [7:0] din;
    bit         ev;
    logic [7:0] eo;
    bit         ep;
  } vec_t;

  vec_t tm[$];
  vec_t ts[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input bit sm, input bit wr, input bit rd, input bit inj,
                     input logic [7:0] addr, input logic [7:0] din,
                     input bit ev, input logic [7:0] eo, input bit ep);
    vec_t v;
    v.sm = sm; v.wr = wr; v.rd = rd; v.inj = inj;
    v.addr = addr; v.din = din; v.ev = ev; v.eo = eo; v.ep = ep;
    if (sm) ts.push_back(v);
    else tm.push_back(v);
  endtask

  task automatic idle_inputs();
    write = 1'b0; read = 1'b0; in = '0; address = '0;
    s_write = 1'b0; s_read = 1'b0; s_in = '0; s_address = '0;
`ifdef MEMORY_SYNC_PARITY_EN
    inject_err = 1'b0;
`endif
  endtask

  task automatic apply(input vec_t v, input string tag, input int i);
    if (v.sm) begin
      s_write = v.wr; s_read = v.rd; s_address = v.addr; s_in = v.din;
    end else begin
      write = v.wr; read = v.rd; address = v.addr; in = v.din;
`ifdef MEMORY_SYNC_PARITY_EN
      inject_err = v.inj;
`endif
    end
    @(posedge clk);
    #1;
    if (v.sm) begin
      check($sformatf("%s%0d valid", tag, i), 32'(s_valid), 32'(v.ev));
      check($sformatf("%s%0d out", tag, i), 32'(s_out), 32'(v.eo));
`ifdef MEMORY_SYNC_PARITY_EN
      check($sformatf("%s%0d parity_err", tag, i), 32'(s_parity_err), 32'(v.ep));
`endif
    end else begin
      check($sformatf("%s%0d valid", tag, i), 32'(valid), 32'(v.ev));
      check($sformatf("%s%0d out", tag, i), 32'(out), 32'(v.eo));
`ifdef MEMORY_SYNC_PARITY_EN
      check($sformatf("%s%0d parity_err", tag, i), 32'(parity_err), 32'(v.ep));
`endif
    end
    idle_inputs();
  endtask

  initial begin
    int   nb, ns, n;
    bit   vseen;
    vec_t v;

    // main instance:   sm wr rd inj addr   din    ev eo     ep
    add(0, 0, 1, 0, 8'd23,  8'h00, 1, 8'h00, 0);
    add(0, 1, 0, 0, 8'd23,  8'd23, 0, 8'h00, 0);
    add(0, 1, 0, 0, 8'd42,  8'd42, 0, 8'h00, 0);
    add(0, 0, 1, 0, 8'd23,  8'h00, 1, 8'd23, 0);
    add(0, 0, 0, 0, 8'd00,  8'h00, 0, 8'd23, 0);
    add(0, 0, 0, 0, 8'd00,  8'h00, 0, 8'd23, 0);
    add(0, 1, 1, 0, 8'd7,   8'hA5, 1, 8'hA5, 0);
    add(0, 0, 1, 0, 8'd42,  8'h00, 1, 8'd42, 0);
    add(0, 0, 1, 0, 8'd7,   8'h00, 1, 8'hA5, 0);
    add(0, 0, 1, 0, 8'd0,   8'h00, 1, 8'h00, 0);
    add(0, 0, 1, 0, 8'd255, 8'h00, 1, 8'h00, 0);
    add(0, 1, 1, 0, 8'd255, 8'h3C, 1, 8'h3C, 0);
    add(0, 1, 0, 0, 8'd0,   8'h77, 0, 8'h3C, 0);
    add(0, 0, 1, 0, 8'd0,   8'h00, 1, 8'h77, 0);
    add(0, 1, 0, 0, 8'd5,   8'h11, 0, 8'h77, 0);
    add(0, 0, 1, 0, 8'd5,   8'h00, 1, 8'h11, 0);
    add(0, 0, 1, 0, 8'd255, 8'h00, 1, 8'h3C, 0);
`ifdef MEMORY_SYNC_PARITY_EN
    add(0, 1, 0, 1, 8'd9,   8'h0F, 0, 8'h3C, 0);
    add(0, 0, 1, 0, 8'd9,   8'h00, 1, 8'h0F, 1);
    add(0, 1, 0, 0, 8'd9,   8'h0F, 0, 8'h0F, 0);
    add(0, 0, 1, 0, 8'd9,   8'h00, 1, 8'h0F, 0);
    add(0, 1, 1, 1, 8'd9,   8'h0E, 1, 8'h0E, 1);
`endif
    // 200-word instance
    add(1, 1, 0, 0, 8'd10,  8'h5A, 0, 8'h00, 0);
    add(1, 1, 0, 0, 8'd210, 8'hFF, 0, 8'h00, 0);
    add(1, 0, 1, 0, 8'd210, 8'h00, 1, 8'h00, 0);
    add(1, 0, 1, 0, 8'd10,  8'h00, 1, 8'h5A, 0);
    add(1, 1, 0, 0, 8'd200, 8'hFF, 0, 8'h5A, 0);
    add(1, 0, 1, 0, 8'd200, 8'h00, 1, 8'h00, 0);
    add(1, 1, 1, 0, 8'd199, 8'hC3, 1, 8'hC3, 0);
    add(1, 0, 1, 0, 8'd199, 8'h00, 1, 8'hC3, 0);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd1);
    check("rst valid", 32'(valid), 32'd0);
    check("rst out", 32'(out), 32'd0);
    check("rst s_busy", 32'(s_busy), 32'd1);
    rst = 1'b0;

    nb = 0; ns = 0; n = 0; vseen = 0;
    while ((nb == 0 || ns == 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (valid || s_valid) vseen = 1;
      if (!busy && nb == 0) nb = n;
      if (!s_busy && ns == 0) ns = n;
    end
    check("sweep256 cycles", 32'(nb), 32'd256);
    check("sweep200 cycles", 32'(ns), 32'd200);
    check("sweep valid quiet", 32'(vseen), 32'd0);

    foreach (tm[i]) apply(tm[i], "main", i);

    // Requests during the sweep, then a reset landing on sweep word 100.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst2 out cleared", 32'(out), 32'd0);
    check("rst2 busy", 32'(busy), 32'd1);
    rst = 1'b0;
    write = 1'b1; read = 1'b1; address = 8'd5; in = 8'hFF;
    vseen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (valid) vseen = 1;
    end
    check("word100 busy", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    nb = 0; n = 0;
    while (nb == 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) vseen = 1;
      if (!busy) nb = n;
    end
    idle_inputs();
    check("resweep cycles", 32'(nb), 32'd256);
    check("busy requests ignored", 32'(vseen), 32'd0);
    v.sm = 0; v.wr = 0; v.rd = 1; v.inj = 0; v.addr = 8'd5; v.din = '0;
    v.ev = 1; v.eo = 8'h00; v.ep = 0;
    apply(v, "resweep_rd", 5);

    foreach (ts[i]) apply(ts[i], "small", i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/memory_sync.md
MEMORY_SYNC -- requirements
Module: memory_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256: number of words; any value 2..65536 SHALL be legal.
REQ-003 The block SHALL have parameter ADDR_W, default 8: address width, with ADDR_W >= ceil(log2(DEPTH)).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in, input, WIDTH bits: write data.
REQ-007 The block SHALL have port address, input, ADDR_W bits: word address for read and write.
REQ-008 The block SHALL have port write, input, 1 bit: write request.
REQ-009 The block SHALL have port read, input, 1 bit: read request.
REQ-010 The block SHALL have port out, output, WIDTH bits: registered read data.
REQ-011 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking new data on out.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the init sweep runs; requests are not accepted while it is high.
REQ-013 The block SHALL have port inject_err, input, 1 bit, and port parity_err, output, 1 bit, present only when MEMORY_SYNC_PARITY_EN is defined.

Function
REQ-014 The block SHALL implement a two-state FSM: INIT and READY.
REQ-015 In INIT, an ADDR_W-bit counter SHALL write zero to word 0, 1, ... DEPTH-1, one word per cycle, with busy=1.
REQ-016 The FSM SHALL move to READY in the cycle after word DEPTH-1 is cleared, so busy is high for exactly DEPTH cycles after rst falls.
REQ-017 While busy=1, read and write SHALL be ignored and valid SHALL stay 0.
REQ-018 In READY, write=1 with address<DEPTH SHALL store in at address on that clock edge.
REQ-019 In READY, read=1 SHALL load out on the same edge and assert valid for exactly one cycle after it; read latency is 1 cycle.
REQ-020 Back-to-back reads SHALL be accepted every cycle; valid SHALL then stay high continuously with out updated each cycle.
REQ-021 When no read is accepted, out SHALL hold its last value and valid SHALL be 0.
REQ-022 If read and write hit the same address in the same cycle, out SHALL return the newly written data (write-first).
REQ-023 If read and write hit different addresses in the same cycle, both SHALL complete independently.
REQ-024 A write to address>=DEPTH SHALL be discarded with no state change.
REQ-025 A read of address>=DEPTH SHALL return out=0 with valid=1.

Reset
REQ-026 While rst=1, the block SHALL force FSM=INIT, counter=0, out=0, valid=0, busy=1 and parity_err=0.
REQ-027 Reset asserted mid-sweep or mid-operation SHALL abort the current activity and restart the sweep from word 0 after rst falls.
REQ-028 Array contents SHALL be undefined only until the sweep completes.

Configuration
REQ-029 With macro MEMORY_SYNC_PARITY_EN defined, each word SHALL store WIDTH+1 bits: the data plus an even-parity bit computed on write.
REQ-030 With MEMORY_SYNC_PARITY_EN defined, write=1 together with inject_err=1 SHALL store the inverted parity bit.
REQ-031 With MEMORY_SYNC_PARITY_EN defined, parity_err SHALL assert together with valid when the stored parity mismatches the read data; the init sweep SHALL write correct parity.
REQ-032 Without MEMORY_SYNC_PARITY_EN, the block SHALL have no parity storage, no inject_err port and no parity_err port; all other behaviour SHALL be identical.

Verification
REQ-033 Pulse rst for 2 cycles (DEPTH=256) -> busy high for exactly 256 cycles, and a read of address 23 returns out=0 with valid=1.
REQ-034 Write 23 to address 23, then write 42 to address 42, then read 23 -> out=23 one cycle later; out holds 23 while idle.
REQ-035 Write 8'hA5 and read address 7 in the same cycle -> out=8'hA5 next cycle.
REQ-036 Issue write/read during busy, then assert rst at sweep word 100 -> requests ignored and busy lasts 256 cycles from the rst release.
REQ-037 Set DEPTH=200 and write 8'hFF to address 210 -> read of 210 returns 0, and address 10 is unchanged.
REQ-038 With MEMORY_SYNC_PARITY_EN defined, write 8'h0F with inject_err=1 and read it back -> parity_err=1 with valid; a clean rewrite of the same word returns parity_err=0.
